// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive blocks: FSM state
// encoding, frame width and the bit layout of the software status word.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;

    localparam int EMPTY_BIT = 0;
    localparam int FULL_BIT  = 1;
    localparam int BUSY_BIT  = 2;
    localparam int OVF_BIT   = 3;
    localparam int COUNT_LSB = 4;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO for the UART transmit queue. A power-of-two circular buffer
// whose pointers wrap naturally; dout always shows the current head so
// the consumer can pop and use the byte in the same cycle. A push into a
// full FIFO is only taken when a pop frees a slot on the same edge.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [UART_DATA_BITS-1:0] din,
    output logic [UART_DATA_BITS-1:0] dout,
    output logic                      full,
    output logic                      empty,
    output logic [DEPTH_LOG2:0]       count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [UART_DATA_BITS-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0]     wr_ptr;
    logic [DEPTH_LOG2-1:0]     rd_ptr;
    logic                      do_push;
    logic                      do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout  = mem[rd_ptr];
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Buffered 8N1 UART transmitter. CPU byte stores land in a FIFO and are
// shifted out LSB first at BAUD_DIV clocks per bit. When the queue still
// holds data at the last stop-bit cycle the next start bit follows with no
// idle gap. A sticky overflow flag records bytes dropped on a full queue.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [UART_DATA_BITS-1:0] wr_data,
    input  logic                      clr_ovf,
    output logic                      tx,
    output logic                      full,
    output logic                      empty,
    output logic                      busy,
    output logic                      overflow,
    output logic [31:0]               status
);

    localparam logic [15:0] BIT_TIME_LAST = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  LAST_BIT      = 3'(UART_DATA_BITS - 1);

    uart_state_t               state;
    uart_state_t               next_state;
    logic [15:0]               bit_timer;
    logic [15:0]               timer_next;
    logic [2:0]                bit_idx;
    logic [2:0]                idx_next;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic [UART_DATA_BITS-1:0] shift_next;
    logic                      tx_reg;
    logic                      tx_next;
    logic                      bit_done;

    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_dout;
    logic [DEPTH_LOG2:0]       fifo_count;

    uart_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (wr_en),
        .pop   (fifo_pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_done = (bit_timer == '0);

    // FSM state register; reset aborts any frame in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: every bit period ends when the bit timer reaches zero.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    next_state = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done && (bit_idx == LAST_BIT)) begin
                    next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    next_state = fifo_empty ? ST_IDLE : ST_START;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output decode: pop strobe and the next line level, timer, index and shift value.
    always_comb begin
        fifo_pop   = 1'b0;
        timer_next = bit_done ? BIT_TIME_LAST : bit_timer - 1'b1;
        idx_next   = bit_idx;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        case (state)
            ST_IDLE: begin
                timer_next = BIT_TIME_LAST;
                tx_next    = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_dout;
                    tx_next    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    idx_next = 3'd0;
                    tx_next  = shift_reg[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx == LAST_BIT) begin
                        tx_next = 1'b1;
                    end else begin
                        shift_next = shift_reg >> 1;
                        idx_next   = bit_idx + 3'd1;
                        tx_next    = shift_reg[1];
                    end
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_dout;
                        tx_next    = 1'b0;
                    end else begin
                        tx_next = 1'b1;
                    end
                end
            end
            default: begin
                tx_next = 1'b1;
            end
        endcase
    end

    // Datapath registers: bit timer, bit index, shift register and the line driver.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_timer <= BIT_TIME_LAST;
            bit_idx   <= 3'd0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            bit_timer <= timer_next;
            bit_idx   <= idx_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    // Sticky overflow: a dropped write sets it and wins over a same-cycle clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr_en && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign tx    = tx_reg;
    assign full  = fifo_full;
    assign empty = fifo_empty;
    assign busy  = (state != ST_IDLE);

    // Status word assembled from registered flags for the CPU load path.
    always_comb begin
        status                                 = '0;
        status[EMPTY_BIT]                      = fifo_empty;
        status[FULL_BIT]                       = fifo_full;
        status[BUSY_BIT]                       = busy;
        status[OVF_BIT]                        = overflow;
        status[COUNT_LSB +: DEPTH_LOG2 + 1]    = fifo_count;
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: a queue-based model of the
// transmitter is compared against the DUT on every cycle, with directed
// scenarios and literal expectations layered on top.
`timescale 1ns/1ps
module tb_uart_tx_queue;

    localparam int BAUD_DIV   = 16;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int FRAME_LEN  = 10 * BAUD_DIV;

    logic        clock;
    logic        reset;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        clr_ovf;
    logic        tx;
    logic        full;
    logic        empty;
    logic        busy;
    logic        overflow;
    logic [31:0] status;

    int tests_run = 0;
    int tests_failed = 0;
    bit chk_en = 0;

    // model state
    logic [7:0] m_q[$];
    bit         m_ovf;
    bit         m_active;
    int         m_cyc;
    logic [9:0] m_frame;
    bit         m_pop_now;
    bit         m_full_pre;
    logic [7:0] m_head;

    logic [7:0] held[$];
    logic [7:0] sent_q[$];

    uart_tx_queue #(
        .BAUD_DIV(BAUD_DIV),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .clr_ovf(clr_ovf),
        .tx(tx),
        .full(full),
        .empty(empty),
        .busy(busy),
        .overflow(overflow),
        .status(status)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit w, input logic [7:0] d, input bit c);
        wr_en   = w;
        wr_data = d;
        clr_ovf = c;
        @(posedge clock);
        #1;
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Waits (bounded) for a start bit seen at a falling clock edge, then samples mid-bit.
    task automatic receiveFrame(output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b  = 8'h00;
        for (int i = 0; i < 2000; i++) begin
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (ok) begin
            repeat (BAUD_DIV / 2) @(negedge clock);
            for (int k = 0; k < 8; k++) begin
                repeat (BAUD_DIV) @(negedge clock);
                b[k] = tx;
            end
            repeat (BAUD_DIV) @(negedge clock);
        end
    endtask

    // Behavioural model: a byte queue feeding a 10-bit frame walked by a cycle counter.
    always @(posedge clock) begin
        if (reset) begin
            m_q.delete();
            m_ovf    = 1'b0;
            m_active = 1'b0;
            m_cyc    = 0;
            m_frame  = 10'h3ff;
        end else begin
            m_full_pre = (m_q.size() == DEPTH);
            m_pop_now  = 1'b0;
            if (!m_active || m_cyc == FRAME_LEN - 1) begin
                if (m_q.size() != 0) m_pop_now = 1'b1;
                else m_active = 1'b0;
            end else begin
                m_cyc++;
            end
            if (m_pop_now) begin
                m_head   = m_q.pop_front();
                m_frame  = {1'b1, m_head, 1'b0};
                m_active = 1'b1;
                m_cyc    = 0;
            end
            if (wr_en && (!m_full_pre || m_pop_now)) m_q.push_back(wr_data);
            if (wr_en && m_full_pre && !m_pop_now) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            logic exp_tx;
            logic [3:0] exp_flags;
            int exp_status;
            exp_tx = m_active ? m_frame[m_cyc / BAUD_DIV] : 1'b1;
            exp_flags = {m_ovf, m_active, (m_q.size() == DEPTH), (m_q.size() == 0)};
            exp_status = (m_q.size() << 4) | (int'(exp_flags));
            checkOutput("tx", 32'(tx), 32'(exp_tx));
            checkOutput("flags", 32'({overflow, busy, full, empty}), 32'(exp_flags));
            checkOutput("status", status, 32'(exp_status));
        end
    end

    initial begin
        #1_000_000;
        tests_failed++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        int a5_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        int busy_cnt;
        int low_cnt;
        bit found;
        bit ok;
        logic [7:0] b;

        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        clr_ovf = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk_en = 1'b1;
        reset  = 1'b0;
        @(negedge clock);
        checkOutput("reset_status", status, 32'h0000_0001);
        checkOutput("reset_tx", 32'(tx), 32'h1);

        // single frame 0xA5
        $display("[TB] single frame 0xA5");
        applyStimulus(1'b1, 8'hA5, 1'b0);
        @(negedge clock);
        checkOutput("a5_pre_tx", 32'(tx), 32'h1);
        checkOutput("a5_not_empty", 32'(empty), 32'h0);
        busy_cnt = 0;
        for (int c = 0; c < 180; c++) begin
            @(negedge clock);
            busy_cnt += int'(busy);
            if (c == 0) checkOutput("a5_start_low", 32'(tx), 32'h0);
            if (c % BAUD_DIV == BAUD_DIV / 2 && c < FRAME_LEN)
                checkOutput("a5_bit", 32'(tx), 32'(a5_bits[c / BAUD_DIV]));
        end
        checkOutput("a5_busy_cycles", 32'(busy_cnt), 32'd160);

        // back-to-back 0x00, 0xFF
        $display("[TB] back-to-back frames");
        applyStimulus(1'b1, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'hFF, 1'b0);
        busy_cnt = 0;
        for (int c = 0; c < 340; c++) begin
            @(negedge clock);
            busy_cnt += int'(busy);
            if (c == 100) checkOutput("b2b_count_1", 32'(status[7:4]), 32'h1);
            if (c == 200) begin
                checkOutput("b2b_count_0", 32'(status[7:4]), 32'h0);
                checkOutput("b2b_empty", 32'(empty), 32'h1);
            end
        end
        checkOutput("b2b_busy_cycles", 32'(busy_cnt), 32'd320);

        // overflow during a frame
        $display("[TB] overflow");
        applyStimulus(1'b1, 8'h11, 1'b0);
        repeat (5) applyStimulus(1'b0, 8'h00, 1'b0);
        held.delete();
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            if (i < 16) held.push_back(b);
            applyStimulus(1'b1, b, 1'b0);
            if (i == 15) begin
                @(negedge clock);
                checkOutput("ovf_full_16", 32'(full), 32'h1);
                checkOutput("ovf_not_yet", 32'(overflow), 32'h0);
            end
        end
        @(negedge clock);
        checkOutput("ovf_status", status, 32'h0000_010E);
        applyStimulus(1'b0, 8'h00, 1'b1);
        @(negedge clock);
        checkOutput("ovf_cleared", status, 32'h0000_0106);

        // write on the final stop cycle with a full queue
        $display("[TB] full write at stop boundary");
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clock);
            #1;
            if (m_active && m_cyc == FRAME_LEN - 1) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("stop_edge_found", 32'(found), 32'h1);
        if (found) begin
            applyStimulus(1'b1, 8'h5A, 1'b0);
            @(negedge clock);
            checkOutput("stop_write_count", status, 32'h0000_0106);
            receiveFrame(b, ok);
            checkOutput("stop_frame_seen", 32'(ok), 32'h1);
            checkOutput("stop_oldest_byte", 32'(b), 32'(held[0]));
        end
        doReset();

        // reset in the middle of the 4th data bit
        $display("[TB] mid-frame reset");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clock);
            #1;
            if (m_active && m_cyc == 70) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("mid_found", 32'(found), 32'h1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("mid_reset_tx", 32'(tx), 32'h1);
        checkOutput("mid_reset_status", status, 32'h0000_0001);
        low_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            low_cnt += int'(!tx);
            busy_cnt += int'(busy);
        end
        checkOutput("mid_no_frames", 32'(low_cnt), 32'h0);
        checkOutput("mid_no_busy", 32'(busy_cnt), 32'h0);

        // random writes and clears
        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++)
            applyStimulus($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 15) == 0);
        doReset();

        // 40-byte stream with polling
        $display("[TB] 40-byte stream");
        sent_q.delete();
        fork
            begin
                int n = 0;
                for (int it = 0; it < 20000 && n < 40; it++) begin
                    if (!full && $urandom_range(0, 3) != 0) begin
                        logic [7:0] w;
                        w = 8'($urandom);
                        sent_q.push_back(w);
                        applyStimulus(1'b1, w, 1'b0);
                        n++;
                    end else begin
                        applyStimulus(1'b0, 8'h00, 1'b0);
                    end
                end
            end
            begin
                logic [7:0] r;
                bit rok;
                @(negedge clock);
                for (int i = 0; i < 40; i++) begin
                    receiveFrame(r, rok);
                    if (!rok) begin
                        checkOutput("stream_timeout", 32'h0, 32'h1);
                        break;
                    end
                    checkOutput("stream_order", 32'(r), 32'(sent_q[i]));
                end
            end
        join
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
